// File: rtl/jcount_decoder.sv
// jcount_decoder: samples an N-bit Johnson code and decodes it to an index and a
// one-hot vector. Each pair of consecutive samples gives a direction, which
// drives a signed net-step position count. Illegal codes and skipped states
// (jumps) are flagged with pulses and a sticky error bit.
module jcount_decoder #(
  parameter int N    = 4,
  parameter int IDXW = 3,
  parameter int PW   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  input  logic [N-1:0]      Q_IN,
  input  logic              CLR_ERR,
  output logic [IDXW-1:0]   INDEX,
  output logic [2*N-1:0]    ONEHOT,
  output logic              LOCKED,
  output logic              STEP,
  output logic              DIR_LEFT,
  output logic              JUMP,
  output logic              ILLEGAL,
  output logic              ERR,
  output logic [PW-1:0]     POS
);

  localparam int NS = 2 * N;

  // Number of legal states, held one bit wider than the index so that the
  // modular difference below can be formed without overflow.
  localparam logic [IDXW:0]   NS_W     = (IDXW+1)'(NS);
  localparam logic [IDXW:0]   NS_M1_W  = (IDXW+1)'(NS - 1);
  localparam logic [IDXW:0]   ONE_W    = {{IDXW{1'b0}}, 1'b1};
  localparam logic [IDXW:0]   ZERO_W   = {(IDXW+1){1'b0}};
  localparam logic [N-1:0]    ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]    ZERO_N   = {N{1'b0}};
  localparam logic [NS-1:0]   OH_ONE   = {{(NS-1){1'b0}}, 1'b1};
  localparam logic [NS-1:0]   OH_ZERO  = {NS{1'b0}};
  localparam logic [PW-1:0]   POS_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   POS_ZERO = {PW{1'b0}};

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // A Johnson code is either all zeros, a run of ones anchored at bit 0, or a
  // run of ones anchored at the MSB. A run anchored at bit 0 has the property
  // that adding one clears every set bit (q & (q+1) == 0); the MSB-anchored
  // form is the same test applied to the inverted code.
  function automatic logic code_is_legal(input logic [N-1:0] q);
    logic [N-1:0] inv;
    logic         ok;
    inv = ~q;
    if (q == ZERO_N) begin
      ok = 1'b1;
    end else if (q[0]) begin
      ok = ((q & (q + ONE_N)) == ZERO_N);
    end else begin
      ok = ((inv & (inv + ONE_N)) == ZERO_N);
    end
    return ok;
  endfunction

  // Position in the left-going sequence: the count of ones for codes anchored
  // at bit 0 (including all-zero), otherwise 2N minus the count of ones.
  function automatic logic [IDXW-1:0] code_index(input logic [N-1:0] q);
    logic [IDXW:0] cnt;
    logic [IDXW:0] rev;
    logic [IDXW-1:0] idx;
    cnt = ZERO_W;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{IDXW{1'b0}}, q[i]};
    end
    rev = NS_W - cnt;
    if (q[0] || (q == ZERO_N)) begin
      idx = cnt[IDXW-1:0];
    end else begin
      idx = rev[IDXW-1:0];
    end
    return idx;
  endfunction

  state_t            state_r;
  logic [IDXW-1:0]   index_r;
  logic [NS-1:0]     onehot_r;
  logic              locked_r;
  logic              step_r;
  logic              dir_left_r;
  logic              jump_r;
  logic              illegal_r;
  logic              err_r;
  logic [PW-1:0]     pos_r;

  logic              sample_legal_s;
  logic [IDXW-1:0]   sample_k_s;
  logic [IDXW:0]     sum_s;
  logic [IDXW:0]     diff_s;
  logic              ev_left_s;
  logic              ev_right_s;
  logic              ev_jump_s;
  logic              ev_illegal_s;

  // Decode the incoming sample and form d = (k - INDEX) mod 2N.
  always_comb begin
    sample_legal_s = code_is_legal(Q_IN);
    sample_k_s     = code_index(Q_IN);
    sum_s          = {1'b0, sample_k_s} + NS_W - {1'b0, index_r};
    if (sum_s >= NS_W) begin
      diff_s = sum_s - NS_W;
    end else begin
      diff_s = sum_s;
    end
  end

  // Classify the current sample into at most one event; nothing happens
  // without CE, and an unlocked decoder only relocks on a legal sample.
  always_comb begin
    ev_left_s    = 1'b0;
    ev_right_s   = 1'b0;
    ev_jump_s    = 1'b0;
    ev_illegal_s = 1'b0;
    if (CE) begin
      if (!sample_legal_s) begin
        ev_illegal_s = 1'b1;
      end else if (state_r == ST_LOCKED) begin
        if (diff_s == ZERO_W) begin
          ev_left_s = 1'b0;
        end else if (diff_s == ONE_W) begin
          ev_left_s = 1'b1;
        end else if (diff_s == NS_M1_W) begin
          ev_right_s = 1'b1;
        end else begin
          ev_jump_s = 1'b1;
        end
      end else begin
        ev_left_s = 1'b0;
      end
    end else begin
      ev_left_s = 1'b0;
    end
  end

  // Lock state machine with all outputs registered; pulses default low.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_UNLOCKED;
      index_r    <= {IDXW{1'b0}};
      onehot_r   <= OH_ZERO;
      locked_r   <= 1'b0;
      step_r     <= 1'b0;
      dir_left_r <= 1'b0;
      jump_r     <= 1'b0;
      illegal_r  <= 1'b0;
      pos_r      <= POS_ZERO;
    end else begin
      step_r    <= ev_left_s | ev_right_s;
      jump_r    <= ev_jump_s;
      illegal_r <= ev_illegal_s;
      if (CE) begin
        if (sample_legal_s) begin
          state_r  <= ST_LOCKED;
          locked_r <= 1'b1;
          index_r  <= sample_k_s;
          onehot_r <= OH_ONE << sample_k_s;
        end else begin
          // INDEX keeps the last good value so software can see where it broke.
          state_r  <= ST_UNLOCKED;
          locked_r <= 1'b0;
          onehot_r <= OH_ZERO;
        end
        if (ev_left_s) begin
          pos_r      <= pos_r + POS_ONE;
          dir_left_r <= 1'b1;
        end else if (ev_right_s) begin
          pos_r      <= pos_r - POS_ONE;
          dir_left_r <= 1'b0;
        end else begin
          pos_r      <= pos_r;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  // Sticky error: a new error in the same cycle as a clear takes priority,
  // and the clear is honoured even when sampling is disabled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_r <= 1'b0;
    end else if (ev_jump_s || ev_illegal_s) begin
      err_r <= 1'b1;
    end else if (CLR_ERR) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign INDEX    = index_r;
  assign ONEHOT   = onehot_r;
  assign LOCKED   = locked_r;
  assign STEP     = step_r;
  assign DIR_LEFT = dir_left_r;
  assign JUMP     = jump_r;
  assign ILLEGAL  = illegal_r;
  assign ERR      = err_r;
  assign POS      = pos_r;

endmodule

// File: tb/tb_jcount_decoder.sv
// Testbench for jcount_decoder (N=4): directed steps feed a reference model that
// pushes expected outputs into a queue; after each clock edge the entry is popped
// and compared against the DUT.
module tb_jcount_decoder;

  logic        CLK;
  logic        RESET;
  logic        CE;
  logic [3:0]  Q_IN;
  logic        CLR_ERR;
  logic [2:0]  INDEX;
  logic [7:0]  ONEHOT;
  logic        LOCKED;
  logic        STEP;
  logic        DIR_LEFT;
  logic        JUMP;
  logic        ILLEGAL;
  logic        ERR;
  logic [15:0] POS;

  typedef struct packed {
    logic [2:0]  index;
    logic [7:0]  onehot;
    logic        locked;
    logic        step;
    logic        dir_left;
    logic        jump;
    logic        illegal;
    logic        err;
    logic [15:0] pos;
  } outs_t;

  outs_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model state
  logic [3:0]  codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                             4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic        m_locked;
  int          m_index;
  logic        m_dir;
  logic        m_err;
  logic [15:0] m_pos;

  jcount_decoder #(.N(4), .IDXW(3), .PW(16)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .Q_IN(Q_IN), .CLR_ERR(CLR_ERR),
    .INDEX(INDEX), .ONEHOT(ONEHOT), .LOCKED(LOCKED), .STEP(STEP),
    .DIR_LEFT(DIR_LEFT), .JUMP(JUMP), .ILLEGAL(ILLEGAL), .ERR(ERR), .POS(POS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic outs_t observed();
    outs_t o;
    o.index = INDEX; o.onehot = ONEHOT; o.locked = LOCKED; o.step = STEP;
    o.dir_left = DIR_LEFT; o.jump = JUMP; o.illegal = ILLEGAL; o.err = ERR;
    o.pos = POS;
    return o;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_index = 0; m_dir = 1'b0; m_err = 1'b0; m_pos = 16'h0000;
  endtask

  // Advance the model by one clock and push the expected outputs.
  task automatic model_step(input logic ce, input logic [3:0] q, input logic clr);
    outs_t e;
    logic  legal;
    int    k;
    int    d;
    e = '0;
    legal = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (codes[i] == q) begin
        legal = 1'b1;
        k = i;
      end
    end
    if (ce) begin
      if (!legal) begin
        e.illegal = 1'b1;
        m_locked = 1'b0;
      end else if (!m_locked) begin
        m_locked = 1'b1;
        m_index = k;
      end else begin
        d = (k - m_index + 8) % 8;
        if (d == 1) begin
          e.step = 1'b1; m_dir = 1'b1; m_pos = m_pos + 16'd1;
        end else if (d == 7) begin
          e.step = 1'b1; m_dir = 1'b0; m_pos = m_pos - 16'd1;
        end else if (d != 0) begin
          e.jump = 1'b1;
        end
        m_index = k;
      end
    end
    if (e.illegal || e.jump) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    e.index = 3'(m_index);
    e.onehot = m_locked ? (8'b0000_0001 << m_index) : 8'b0000_0000;
    e.locked = m_locked;
    e.dir_left = m_dir;
    e.err = m_err;
    e.pos = m_pos;
    exp_q.push_back(e);
  endtask

  // Drive one sample, clock it, then pop and compare away from the edge.
  task automatic cycle(input logic ce, input logic [3:0] q, input logic clr, input string tag);
    outs_t e;
    outs_t o;
    CE = ce; Q_IN = q; CLR_ERR = clr;
    model_step(ce, q, clr);
    @(posedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: scoreboard empty, observed=%h required=entry", tag, observed());
    end else begin
      e = exp_q.pop_front();
      o = observed();
      assert (o === e) else begin
        n_errors++;
        $error("FAIL %s: observed idx=%0d oh=%h lk=%b st=%b dl=%b jp=%b il=%b er=%b pos=%h required idx=%0d oh=%h lk=%b st=%b dl=%b jp=%b il=%b er=%b pos=%h",
               tag, o.index, o.onehot, o.locked, o.step, o.dir_left, o.jump, o.illegal, o.err, o.pos,
               e.index, e.onehot, e.locked, e.step, e.dir_left, e.jump, e.illegal, e.err, e.pos);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    outs_t o;
    o = observed();
    n_checks++;
    assert (o === outs_t'(0)) else begin
      n_errors++;
      $error("FAIL %s: observed=%h required=%h", tag, o, outs_t'(0));
    end
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b0; Q_IN = 4'b0000; CLR_ERR = 1'b0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    check_zero("reset_state");
    RESET = 1'b0;

    // Lock on 0000, then walk the full left sequence back to 0000.
    cycle(1'b1, 4'b0000, 1'b0, "lock0");
    for (int i = 1; i <= 8; i++) cycle(1'b1, codes[i % 8], 1'b0, "left_walk");
    cycle(1'b1, 4'b0000, 1'b0, "hold0");

    // Fresh lock then a right wrap 0 -> 7.
    @(negedge CLK); RESET = 1'b1; @(negedge CLK); RESET = 1'b0;
    model_reset();
    cycle(1'b1, 4'b0000, 1'b0, "relock0");
    cycle(1'b1, 4'b1000, 1'b0, "right_wrap");

    // Walk left to 0011, then an illegal code and a relock without a step.
    cycle(1'b1, 4'b0000, 1'b0, "left_wrap");
    cycle(1'b1, 4'b0001, 1'b0, "to1");
    cycle(1'b1, 4'b0011, 1'b0, "to2");
    cycle(1'b1, 4'b0101, 1'b0, "illegal");
    cycle(1'b1, 4'b0111, 1'b0, "relock3");

    // Step right to 0001, then a jump with a simultaneous clear.
    cycle(1'b1, 4'b0011, 1'b0, "right2");
    cycle(1'b1, 4'b0001, 1'b0, "right1");
    cycle(1'b1, 4'b0111, 1'b1, "jump_clr");
    cycle(1'b1, 4'b0111, 1'b1, "clr_err");

    // CE low: inputs change but nothing is evaluated; a clear still works.
    cycle(1'b1, 4'b1010, 1'b0, "illegal2");
    cycle(1'b0, 4'b1111, 1'b0, "ce0_a");
    cycle(1'b0, 4'b0110, 1'b1, "ce0_clr");
    cycle(1'b0, 4'b1100, 1'b0, "ce0_b");
    cycle(1'b1, 4'b1110, 1'b0, "relock5");
    cycle(1'b1, 4'b1111, 1'b0, "right4");

    // Mixed random traffic: mostly small moves, some jumps and junk codes.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] q;
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) q = codes[(m_index + ((r < 3) ? 1 : 7) + 8) % 8];
      else if (r < 8) q = codes[$urandom_range(0, 7)];
      else q = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 4) != 0), q, ($urandom_range(0, 5) == 0), "random");
    end

    // Asynchronous reset between edges clears everything immediately.
    cycle(1'b1, 4'b0001, 1'b0, "pre_rst");
    #2;
    RESET = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    cycle(1'b1, 4'b0011, 1'b0, "post_rst_lock");
    cycle(1'b1, 4'b0111, 1'b0, "post_rst_step");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jcount_decoder.md
Name: jcount_decoder

Overview:
- Receive-side companion to the team's Johnson counter.
- Samples an N-bit Johnson code and decodes it to a binary index and a one-hot vector.
- Infers the shift direction from each pair of consecutive samples, keeps a signed net-step position count, and flags illegal codes and skipped states.
- Sits between a Johnson-counter output (or a Johnson-coded encoder bus) and downstream control logic.

Parameters:
- N, 4, Johnson code width; 2N legal states; N >= 2.
- IDXW, 3, INDEX width; 2^IDXW >= 2N.
- PW, 16, POS width; two's complement.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CE  in  1  sample enable; Q_IN is evaluated only on edges where CE=1.
- Q_IN  in  N  Johnson code; synchronous to CLK.
- CLR_ERR  in  1  clears sticky ERR.
- INDEX  out  IDXW  decoded state index.
- ONEHOT  out  2N  bit INDEX set when LOCKED=1; all zero when unlocked.
- LOCKED  out  1  last evaluated sample was legal.
- STEP  out  1  one-cycle pulse: legal +/-1 transition.
- DIR_LEFT  out  1  direction of last STEP: 1 = left (+1), 0 = right (-1).
- JUMP  out  1  one-cycle pulse: legal code but delta not in {0, +1, -1}.
- ILLEGAL  out  1  one-cycle pulse: sample is not a Johnson code.
- ERR  out  1  sticky error.
- POS  out  PW  net step count.

Behaviour:
- Code map (left sequence from 0):
  - For k in 0..N: code = k ones from bit 0 upward.
  - For k in N+1..2N-1: code = (2N-k) ones from MSB downward.
  - N=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Legality and decode:
  - Q_IN = 0: legal, k = 0.
  - Q_IN[0] = 1: legal only if the ones are contiguous from bit 0; k = popcount.
  - Q_IN[0] = 0, nonzero: legal only if the ones are contiguous from MSB; k = 2N - popcount.
  - Anything else is illegal.
- Latency: every output is a register. Outputs reflect the Q_IN sampled at the preceding CE=1 edge.
- Reset (async, immediate): INDEX=0, ONEHOT=0, LOCKED=0, STEP=0, DIR_LEFT=0, JUMP=0, ILLEGAL=0, ERR=0, POS=0.
- State machine (two states):
  - UNLOCKED (reset state), legal sample → LOCKED; INDEX=k; no STEP/JUMP; POS unchanged.
  - UNLOCKED, illegal sample → stay UNLOCKED; ILLEGAL=1; ERR set.
  - LOCKED, legal sample: compute d = (k - INDEX) mod 2N, then INDEX=k and:
    - d=0: hold; no pulse.
    - d=1: STEP=1, DIR_LEFT=1, POS+1.
    - d=2N-1: STEP=1, DIR_LEFT=0, POS-1.
    - other d: JUMP=1; ERR set; POS unchanged; stay LOCKED.
  - LOCKED, illegal sample → UNLOCKED; ILLEGAL=1; ERR set; INDEX holds last value; ONEHOT=0.
- Wrap-around:
  - Index 2N-1 → 0 is a left step; 0 → 2N-1 is a right step.
  - POS wraps modulo 2^PW with no saturation.
- Pulses: STEP, JUMP and ILLEGAL are high for exactly one cycle and at most one is high per cycle.
- CE=0: no evaluation; pulses drop to 0; all other state holds.
- ERR: set by JUMP or ILLEGAL; cleared by CLR_ERR. A set in the same cycle as CLR_ERR wins. CLR_ERR works regardless of CE.
- DIR_LEFT changes only on STEP.
- Reset mid-stream: returns to UNLOCKED; the first legal sample after reset relocks without a STEP.

Test Plan:
- RESET pulse, then CE=1, Q_IN=0000 → next cycle LOCKED=1, INDEX=0, ONEHOT=0x01, STEP=0, POS=0.
- From locked 0000, left sequence 0001, 0011, ..., 1000, 0000, one per cycle:
  - STEP=1 every cycle, DIR_LEFT=1, INDEX 1..7 then 0.
  - POS=8; ERR=0.
- From fresh lock on 0000, Q_IN=1000 → INDEX=7, STEP=1, DIR_LEFT=0, POS=0xFFFF.
- Locked at 0011, Q_IN=0101:
  - ILLEGAL=1, LOCKED=0, ONEHOT=0, ERR=1, INDEX=2.
  - Then Q_IN=0111 → LOCKED=1, INDEX=3, STEP=0.
- Locked at 0001, Q_IN=0111 with CLR_ERR=1 → JUMP=1, INDEX=3, POS unchanged, ERR=1. Next cycle CLR_ERR=1 → ERR=0.
- CE=0 while Q_IN changes → outputs hold, no pulses. Async RESET asserted mid-stream → all outputs zero before the next CLK edge.
